bus_arbiter: RTL and testbench

- Shares the single downstream memory port between the core's instruction-fetch requester (I-side) and load/store requester (D-side).
- Sits between the pipeline's ibus/dbus request logic and the memory/cache interface.
- Uses the split valid / addr_ok / data_ok handshake.
- One transaction outstanding at a time.
- Contention is resolved by D-first round-robin, or strict D priority, selected by parameter.

---
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-requester arbiter sharing one split-handshake memory port between the
// instruction-fetch (I) and load/store (D) sides, one transaction in flight.
module bus_arbiter #(
  parameter bit          FAIR = 1'b1,
  parameter int unsigned AW   = 32
) (
  input  logic          clk,
  input  logic          resetn,
  // I-side requester
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  output logic          i_addr_ok,
  output logic          i_data_ok,
  output logic [31:0]   i_data,
  // D-side requester
  input  logic          d_valid,
  input  logic [AW-1:0] d_addr,
  input  logic [2:0]    d_size,
  input  logic [3:0]    d_strobe,
  input  logic [31:0]   d_wdata,
  output logic          d_addr_ok,
  output logic          d_data_ok,
  output logic [31:0]   d_data,
  // downstream memory port
  output logic          m_valid,
  output logic [AW-1:0] m_addr,
  output logic [2:0]    m_size,
  output logic [3:0]    m_strobe,
  output logic [31:0]   m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [31:0]   m_data
);

  localparam logic [2:0] I_SIZE = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  state_e state_q, state_d;
  side_e  owner_q, owner_d;
  side_e  last_q,  last_d;
  side_e  grant_c;
  logic   owner_valid_c;
  logic   accept_c;
  logic   done_c;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      owner_q <= SIDE_I;
      last_q  <= SIDE_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Grant selection: a lone requester wins; on contention, FAIR alternates
  // away from the previous grantee, otherwise D always wins.
  always_comb begin
    grant_c = SIDE_I;
    if (i_valid && d_valid) begin
      if (FAIR) begin
        grant_c = (last_q == SIDE_I) ? SIDE_D : SIDE_I;
      end else begin
        grant_c = SIDE_D;
      end
    end else if (d_valid) begin
      grant_c = SIDE_D;
    end
  end

  always_comb begin
    owner_valid_c = (owner_q == SIDE_D) ? d_valid : i_valid;
  end

  // Next-state and downstream request drive.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    accept_c = 1'b0;
    done_c   = 1'b0;
    m_valid  = 1'b0;
    m_addr   = '0;
    m_size   = '0;
    m_strobe = '0;
    m_wdata  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid || d_valid) begin
          owner_d = grant_c;
          last_d  = grant_c;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        // A withdrawn request is never presented downstream, so no handshake.
        if (!owner_valid_c) begin
          state_d = S_IDLE;
        end else begin
          m_valid = 1'b1;
          if (owner_q == SIDE_D) begin
            m_addr   = d_addr;
            m_size   = d_size;
            m_strobe = d_strobe;
            m_wdata  = d_wdata;
          end else begin
            m_addr   = i_addr;
            m_size   = I_SIZE;
          end
          if (m_addr_ok) begin
            accept_c = 1'b1;
            if (m_data_ok) begin
              done_c  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (m_data_ok) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshakes are steered to the owner only.
  always_comb begin
    i_addr_ok = accept_c && (owner_q == SIDE_I);
    d_addr_ok = accept_c && (owner_q == SIDE_D);
    i_data_ok = done_c   && (owner_q == SIDE_I);
    d_data_ok = done_c   && (owner_q == SIDE_D);
  end

  assign i_data = m_data;
  assign d_data = m_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed cycle table, hand-written corner sequences
// and random traffic, all against a behavioural model of both FAIR settings.
module tb_bus_arbiter;

  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_0010;
  localparam logic [31:0] DW = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iv, dv, maok, mdok;
  logic [31:0] ia, da, dw, md;
  logic [2:0]  dsz;
  logic [3:0]  dst;

  // index 0: strict D priority, index 1: round-robin
  logic        iaok_o [2];
  logic        idok_o [2];
  logic [31:0] idata_o[2];
  logic        daok_o [2];
  logic        ddok_o [2];
  logic [31:0] ddata_o[2];
  logic        mv_o   [2];
  logic [31:0] ma_o   [2];
  logic [2:0]  msz_o  [2];
  logic [3:0]  mst_o  [2];
  logic [31:0] mwd_o  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0 idle, 1 request presented, 2 awaiting data
  int ph    [2];
  bit own_d [2];
  bit last_d[2];

  always #5 clk = ~clk;

  bus_arbiter #(.FAIR(1'b0), .AW(32)) u_sp (
    .clk(clk), .resetn(resetn),
    .i_valid(iv), .i_addr(ia), .i_addr_ok(iaok_o[0]), .i_data_ok(idok_o[0]), .i_data(idata_o[0]),
    .d_valid(dv), .d_addr(da), .d_size(dsz), .d_strobe(dst), .d_wdata(dw),
    .d_addr_ok(daok_o[0]), .d_data_ok(ddok_o[0]), .d_data(ddata_o[0]),
    .m_valid(mv_o[0]), .m_addr(ma_o[0]), .m_size(msz_o[0]), .m_strobe(mst_o[0]), .m_wdata(mwd_o[0]),
    .m_addr_ok(maok), .m_data_ok(mdok), .m_data(md)
  );

  bus_arbiter #(.FAIR(1'b1), .AW(32)) u_rr (
    .clk(clk), .resetn(resetn),
    .i_valid(iv), .i_addr(ia), .i_addr_ok(iaok_o[1]), .i_data_ok(idok_o[1]), .i_data(idata_o[1]),
    .d_valid(dv), .d_addr(da), .d_size(dsz), .d_strobe(dst), .d_wdata(dw),
    .d_addr_ok(daok_o[1]), .d_data_ok(ddok_o[1]), .d_data(ddata_o[1]),
    .m_valid(mv_o[1]), .m_addr(ma_o[1]), .m_size(msz_o[1]), .m_strobe(mst_o[1]), .m_wdata(mwd_o[1]),
    .m_addr_ok(maok), .m_data_ok(mdok), .m_data(md)
  );

  typedef struct {
    logic        iv, dv, maok, mdok;
    logic [31:0] md;
    logic        e_mv;
    logic [31:0] e_ma;
    logic [3:0]  e_mst;
    logic        e_iaok, e_idok, e_daok, e_ddok;
  } vec_t;

  function automatic vec_t v(input logic i_v, input logic d_v, input logic a_ok, input logic d_ok,
                             input logic [31:0] mdat, input logic e_mv, input logic [31:0] e_ma,
                             input logic [3:0] e_mst, input logic e_iaok, input logic e_idok,
                             input logic e_daok, input logic e_ddok);
    vec_t r;
    r.iv = i_v; r.dv = d_v; r.maok = a_ok; r.mdok = d_ok; r.md = mdat;
    r.e_mv = e_mv; r.e_ma = e_ma; r.e_mst = e_mst;
    r.e_iaok = e_iaok; r.e_idok = e_idok; r.e_daok = e_daok; r.e_ddok = e_ddok;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      ph[f] = 0; own_d[f] = 1'b0; last_d[f] = 1'b0;
    end
  endtask

  // Expected outputs of instance f from the model and the current inputs.
  task automatic model_check(input int f);
    bit          od, mv, acc, dn;
    logic [31:0] ema, ewd;
    logic [2:0]  esz;
    logic [3:0]  est;
    string       p;
    p   = (f == 1) ? "rr " : "sp ";
    od  = own_d[f];
    mv  = (ph[f] == 1) && (od ? dv : iv);
    ema = mv ? (od ? da : ia) : 32'h0;
    esz = mv ? (od ? dsz : 3'b010) : 3'b000;
    est = (mv && od) ? dst : 4'h0;
    ewd = (mv && od) ? dw : 32'h0;
    acc = mv && maok;
    dn  = (acc && mdok) || (ph[f] == 2 && mdok);
    chk({p, "m_valid"},   32'(mv_o[f]),   32'(mv));
    chk({p, "m_addr"},    ma_o[f],        ema);
    chk({p, "m_size"},    32'(msz_o[f]),  32'(esz));
    chk({p, "m_strobe"},  32'(mst_o[f]),  32'(est));
    chk({p, "m_wdata"},   mwd_o[f],       ewd);
    chk({p, "i_addr_ok"}, 32'(iaok_o[f]), 32'(acc && !od));
    chk({p, "d_addr_ok"}, 32'(daok_o[f]), 32'(acc && od));
    chk({p, "i_data_ok"}, 32'(idok_o[f]), 32'(dn && !od));
    chk({p, "d_data_ok"}, 32'(ddok_o[f]), 32'(dn && od));
    chk({p, "i_data"},    idata_o[f],     md);
    chk({p, "d_data"},    ddata_o[f],     md);
  endtask

  task automatic model_advance();
    bit w, ov;
    for (int f = 0; f < 2; f++) begin
      case (ph[f])
        0: if (iv || dv) begin
          w = (iv && dv) ? ((f == 1) ? !last_d[f] : 1'b1) : dv;
          own_d[f] = w; last_d[f] = w; ph[f] = 1;
        end
        1: begin
          ov = own_d[f] ? dv : iv;
          if (!ov) ph[f] = 0;
          else if (maok) ph[f] = mdok ? 0 : 2;
        end
        default: if (mdok) ph[f] = 0;
      endcase
    end
  endtask

  // Called right after a falling edge with inputs already applied.
  task automatic step();
    #1;
    model_check(0);
    model_check(1);
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    iv = 0; dv = 0; maok = 0; mdok = 0; md = 0;
    ia = IA; da = DA; dw = DW; dsz = 3'b010; dst = 4'hF;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    model_reset();
    @(negedge clk);
    #1;
    model_check(0);
    model_check(1);
    @(negedge clk);
    resetn = 1;
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = v(1, 0, 0, 0, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 1, 1, 32'h3C1D_0001, 1, IA,    4'h0, 1, 1, 0, 0);
    tbl[2]  = v(0, 1, 1, 1, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);
    tbl[3]  = v(0, 1, 1, 0, 32'h0,         1, DA,    4'hF, 0, 0, 1, 0);
    tbl[4]  = v(0, 0, 0, 0, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);
    tbl[5]  = v(0, 0, 0, 0, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);
    tbl[6]  = v(0, 0, 0, 1, 32'h1234_5678, 0, 32'h0, 4'h0, 0, 0, 0, 1);
    tbl[7]  = v(1, 1, 0, 0, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);
    tbl[8]  = v(1, 1, 1, 1, 32'hA5A5_A5A5, 1, IA,    4'h0, 1, 1, 0, 0);
    tbl[9]  = v(1, 1, 1, 1, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);
    tbl[10] = v(1, 1, 1, 1, 32'hC0FF_EE00, 1, DA,    4'hF, 0, 0, 1, 1);
    tbl[11] = v(1, 1, 1, 1, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);
    tbl[12] = v(1, 1, 1, 1, 32'h0,         1, IA,    4'h0, 1, 1, 0, 0);
    tbl[13] = v(0, 1, 0, 0, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);
    tbl[14] = v(0, 1, 0, 0, 32'h0,         1, DA,    4'hF, 0, 0, 0, 0);
    tbl[15] = v(0, 0, 1, 0, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);
    tbl[16] = v(0, 0, 0, 1, 32'h0,         0, 32'h0, 4'h0, 0, 0, 0, 0);

    clear_inputs();
    resetn = 0;
    model_reset();
    #1;
    chk("reset m_valid",   32'(mv_o[1]),   32'h0);
    chk("reset i_addr_ok", 32'(iaok_o[1]), 32'h0);
    chk("reset d_data_ok", 32'(ddok_o[1]), 32'h0);
    do_reset();

    // Directed table against the round-robin instance, cycle by cycle.
    for (int k = 0; k < 17; k++) begin
      iv = tbl[k].iv; dv = tbl[k].dv; maok = tbl[k].maok; mdok = tbl[k].mdok; md = tbl[k].md;
      #1;
      chk($sformatf("tbl%0d m_valid", k),   32'(mv_o[1]),   32'(tbl[k].e_mv));
      chk($sformatf("tbl%0d m_addr", k),    ma_o[1],        tbl[k].e_ma);
      chk($sformatf("tbl%0d m_strobe", k),  32'(mst_o[1]),  32'(tbl[k].e_mst));
      chk($sformatf("tbl%0d i_addr_ok", k), 32'(iaok_o[1]), 32'(tbl[k].e_iaok));
      chk($sformatf("tbl%0d i_data_ok", k), 32'(idok_o[1]), 32'(tbl[k].e_idok));
      chk($sformatf("tbl%0d d_addr_ok", k), 32'(daok_o[1]), 32'(tbl[k].e_daok));
      chk($sformatf("tbl%0d d_data_ok", k), 32'(ddok_o[1]), 32'(tbl[k].e_ddok));
      if (tbl[k].e_idok) chk($sformatf("tbl%0d i_data", k), idata_o[1], tbl[k].md);
      if (tbl[k].e_ddok) chk($sformatf("tbl%0d d_data", k), ddata_o[1], tbl[k].md);
      step();
    end

    // Asynchronous reset while waiting for read data.
    do_reset();
    iv = 1;                   step();
    maok = 1; mdok = 0;       step();
    maok = 0;                 step();
    iv = 0; mdok = 1;
    #1;
    resetn = 0;
    model_reset();
    #1;
    chk("midrst m_valid",   32'(mv_o[1]),   32'h0);
    chk("midrst i_addr_ok", 32'(iaok_o[1]), 32'h0);
    chk("midrst i_data_ok", 32'(idok_o[1]), 32'h0);
    chk("midrst sp i_data_ok", 32'(idok_o[0]), 32'h0);
    @(negedge clk);
    resetn = 1;
    step();                   // stray m_data_ok in IDLE
    iv = 1; mdok = 0;         step();
    maok = 1; mdok = 1; md = 32'h0BAD_F00D;
    #1;
    chk("regrant i_addr_ok", 32'(iaok_o[1]), 32'h1);
    chk("regrant m_addr",    ma_o[1],        IA);
    step();

    // Continuous contention, single-cycle downstream: D,I,D,I vs. always D.
    do_reset();
    iv = 1; dv = 1; maok = 1; mdok = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("cont%0d rr d_addr_ok", k), 32'(daok_o[1]), 32'(k % 4 == 1));
      chk($sformatf("cont%0d rr i_addr_ok", k), 32'(iaok_o[1]), 32'(k % 4 == 3));
      chk($sformatf("cont%0d sp d_addr_ok", k), 32'(daok_o[0]), 32'(k % 2 == 1));
      chk($sformatf("cont%0d sp i_addr_ok", k), 32'(iaok_o[0]), 32'h0);
      step();
    end

    // Random traffic, including withdrawn requests and stray responses.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 1000 == 999) do_reset();
      iv   = ($urandom_range(0, 3) != 0);
      dv   = ($urandom_range(0, 3) != 0);
      ia   = $urandom;
      da   = $urandom;
      dw   = $urandom;
      dsz  = 3'($urandom_range(0, 7));
      dst  = 4'($urandom);
      maok = 1'($urandom_range(0, 1));
      mdok = ($urandom_range(0, 2) == 0);
      md   = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
